// File: rtl/bsg_link_tx_pkg.sv
// Shared state type and sizing helper for the SDR link transmitter credit logic.
package bsg_link_tx_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

    // The counter must reach 2^lg_fifo_depth inclusive, so it needs one bit beyond the log.
    function automatic int credit_width(input int lg_fifo_depth);
        return lg_fifo_depth + 1;
    endfunction

endpackage

// File: rtl/bsg_link_tx_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module bsg_link_tx_credit_counter
    import bsg_link_tx_pkg::*;
#(
    parameter int lg_fifo_depth_p        = 3,
    parameter int lg_credit_decimation_p = 0,
    localparam int cw                    = credit_width(lg_fifo_depth_p)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec,
    input  logic          inc,
    output logic [cw-1:0] credits,
    output logic          overflow
);

    localparam int max_int  = 1 << lg_fifo_depth_p;
    localparam int step_int = 1 << lg_credit_decimation_p;
    localparam logic [cw:0] max_credits = max_int[cw:0];
    localparam logic [cw:0] step        = step_int[cw:0];
    localparam logic [cw:0] one         = {{cw{1'b0}}, 1'b1};

    logic [cw:0] sum;
    logic        over;

    // One extra bit of headroom lets a token at full credits be seen before saturating.
    always_comb begin
        sum = {1'b0, credits};
        if (inc) begin
            sum = sum + step;
        end
        if (dec) begin
            sum = sum - one;
        end
        over = inc && (sum > max_credits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits  <= max_credits[cw-1:0];
            overflow <= 1'b0;
        end else begin
            credits <= over ? max_credits[cw-1:0] : sum[cw-1:0];
            if (over) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_link_sdr_tx_credit.sv
// SDR link transmitter gated by credits returned from the remote receive buffer.
// Build macro BSG_LINK_TX_CREDIT_STATS_EN enables the saturating words-sent counter.
module bsg_link_sdr_tx_credit
    import bsg_link_tx_pkg::*;
#(
    parameter     width_p                = "inv",
    parameter int lg_fifo_depth_p        = 3,
    parameter int lg_credit_decimation_p = 0,
    parameter int init_cycles_p          = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic               token_i,
    output logic [width_p-1:0] link_data_o,
    output logic               link_v_o,
    output logic               overflow_o,
    output logic [31:0]        sent_count_o
);

    localparam int cw        = credit_width(lg_fifo_depth_p);
    localparam int init_last = (init_cycles_p > 0) ? init_cycles_p - 1 : 0;
    localparam int iw        = (init_last > 0) ? $clog2(init_last + 1) : 1;
    localparam logic [iw-1:0] init_last_c = iw'(init_last);

    tx_state_e     state;
    logic [iw-1:0] init_count;
    logic [cw-1:0] credits;
    logic          accept;

    // reset_n_i is expected to be deasserted synchronously to clk_i by its source.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= INIT;
            init_count <= '0;
        end else if (state == INIT) begin
            if (init_count == init_last_c) begin
                state <= RUN;
            end else begin
                init_count <= init_count + iw'(1);
            end
        end
    end

    assign ready_o = (state == RUN) && (credits != '0);
    assign accept  = v_i && ready_o;

    bsg_link_tx_credit_counter #(
        .lg_fifo_depth_p        (lg_fifo_depth_p),
        .lg_credit_decimation_p (lg_credit_decimation_p)
    ) credit_counter (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .dec      (accept),
        .inc      (token_i),
        .credits  (credits),
        .overflow (overflow_o)
    );

    // Link outputs are driven straight from these flops toward the PHY.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            link_v_o    <= 1'b0;
            link_data_o <= '0;
        end else begin
            link_v_o <= accept;
            if (accept) begin
                link_data_o <= data_i;
            end
        end
    end

`ifdef BSG_LINK_TX_CREDIT_STATS_EN
    logic [31:0] sent_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_count <= '0;
        end else if (accept && (sent_count != '1)) begin
            sent_count <= sent_count + 32'd1;
        end
    end

    assign sent_count_o = sent_count;
`else
    assign sent_count_o = '0;
`endif

endmodule
